bmu_req_arbiter: RTL
====================

Name: bmu_req_arbiter

Overview:
Shares one BMU instance between two requesters: r0 is the core execute pipe and r1 is the CSR path. Each requester issues through a valid/ready handshake. The block round-robin arbitrates, registers the winning operation onto the BMU input pins, and tracks in-flight ownership in a tag pipeline. It routes each BMU result and error back to the requester that issued it, and supports a pipeline flush with a drain phase.

Parameters:
AP_W, 22, width of the packed BMU opcode vector (ap).
BMU_LAT, 1, cycles from bmu_valid_in high to bmu_result_ff/bmu_error valid; legal range 1..4.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  kill all in-flight ops and block new issue
r0_req_valid  in  1  r0 request valid
r0_req_ready  out  1  r0 request accepted this cycle
r0_a, r0_b  in  32  r0 operands
r0_ap  in  AP_W  r0 opcode vector
r1_req_valid  in  1  r1 request valid
r1_req_ready  out  1  r1 request accepted this cycle
r1_a, r1_b  in  32  r1 operands
r1_ap  in  AP_W  r1 opcode vector
r1_csr_ren  in  1  r1 CSR read enable
r1_csr_rddata  in  32  r1 CSR read data
bmu_valid_in  out  1  BMU issue valid
bmu_a_in, bmu_b_in  out  32  BMU operands
bmu_ap  out  AP_W  BMU opcode vector
bmu_csr_ren_in  out  1  BMU CSR read enable
bmu_csr_rddata_in  out  32  BMU CSR read data
bmu_result_ff  in  32  BMU result
bmu_error  in  1  BMU error flag
r0_rsp_valid, r1_rsp_valid  out  1  response strobes, one-hot or zero
rsp_result  out  32  shared response data
rsp_error  out  1  shared response error
busy  out  1  FSM state not IDLE

Behaviour:
- Reset: every registered output is 0, including bmu_ap and bmu_csr_rddata_in. Tag pipeline cleared, FSM = IDLE, last_gnt = r1 so r0 wins the first contest.
- Arbitration, combinational:
  - Only one requester valid: it is granted.
  - Both valid: the requester not in last_gnt is granted.
  - rX_req_ready = grant to X and state != DRAIN and !flush and !rst.
  - A transfer happens when valid and ready are both high. Ready may depend on valid, but valid must not depend on ready.
  - last_gnt updates only on a transfer.
- Issue register, updated on the transfer edge:
  - bmu_valid_in = 1 for exactly one cycle per transfer. bmu_a_in, bmu_b_in and bmu_ap take the winner's values.
  - Winner r1: bmu_csr_ren_in and bmu_csr_rddata_in take r1_csr_ren and r1_csr_rddata.
  - Winner r0: bmu_csr_ren_in and bmu_csr_rddata_in are forced to 0.
  - No transfer: bmu_valid_in = 0 and all data fields hold their previous values.
- Tag pipeline: BMU_LAT stages of {valid, owner} entered alongside bmu_valid_in. Throughput is one op per cycle; there is no BMU backpressure.
- Response, combinational from the last tag stage:
  - r(owner)_rsp_valid = tag valid.
  - rsp_result = bmu_result_ff; rsp_error = bmu_error & tag valid.
  - No tag: both strobes 0, rsp_error 0, rsp_result = 0.
  - A bmu_error with no tag present is ignored.
- Latency: response appears 1+BMU_LAT cycles after the transfer edge. Responses have no backpressure; requesters must accept them.
- FSM:
  - IDLE → RUN on a transfer.
  - RUN → IDLE when the issue register and all tag stages are empty and no transfer occurs.
  - Any state → DRAIN on flush. In that cycle the issue valid and all tag valids clear, so no rsp_valid appears for killed ops, and drain_cnt loads BMU_LAT.
  - DRAIN: ready = 0 for both requesters; drain_cnt decrements each cycle; at 0 → IDLE.
  - flush while already in DRAIN reloads drain_cnt.
- Simultaneous events:
  - flush and a requester valid in the same cycle: no transfer.
  - rst overrides flush. rst mid-operation drops all in-flight ops with no response.

Optional Feature:
BMU_ARB_PERF_EN:
- Defined: adds outputs perf_gnt0 and perf_gnt1 (32-bit, wrapping), which count transfers per requester. Also adds perf_err (16-bit, saturating at 0xFFFF), which counts responses with rsp_error = 1. All three are cleared by rst and unaffected by flush.
- Undefined: these ports and counters are absent.

Test Plan:
1. BMU_LAT=1; r0 sends ap.add, a=5, b=7; the BMU model returns 12 → r0_rsp_valid=1 and rsp_result=12 at transfer+2, r1_rsp_valid=0, busy falls the following cycle.
2. Both requesters held valid for 4 cycles after reset → transfer order r0, r1, r0, r1; responses return in the same order with matching owners.
3. r1 sends r1_csr_ren=1, r1_csr_rddata=0xA5A50000, then r0 sends → bmu_csr_ren_in/bmu_csr_rddata_in read 1/0xA5A50000 for the r1 issue, then 0/0 for the r0 issue.
4. flush one cycle after an r0 transfer (BMU_LAT=2) → no r0_rsp_valid for that op; both ready signals 0 for 2 cycles; busy goes 1 then 0; the next transfer is accepted afterwards.
5. BMU model asserts bmu_error=1 on an r1 op → r1_rsp_valid=1 with rsp_error=1. bmu_error=1 with no tag in flight → rsp_error=0. With BMU_ARB_PERF_EN defined, perf_err increments by exactly 1.
6. rst asserted while two ops are in flight → next cycle all outputs 0, no rsp_valid ever appears for those ops; with both requesters valid after reset, r0 is granted first.

Source files
------------

// File: rtl/bmu_req_arbiter.sv
// rtl/bmu_req_arbiter.sv - round-robin front end sharing one BMU between the execute pipe (r0) and the CSR path (r1)
// Optional per-requester grant and error counters are compiled in when BMU_ARB_PERF_EN is defined.

module bmu_req_arbiter #(
  parameter int AP_W    = 22,
  parameter int BMU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            r0_req_valid,
  output logic            r0_req_ready,
  input  logic [31:0]     r0_a,
  input  logic [31:0]     r0_b,
  input  logic [AP_W-1:0] r0_ap,
  input  logic            r1_req_valid,
  output logic            r1_req_ready,
  input  logic [31:0]     r1_a,
  input  logic [31:0]     r1_b,
  input  logic [AP_W-1:0] r1_ap,
  input  logic            r1_csr_ren,
  input  logic [31:0]     r1_csr_rddata,
  output logic            bmu_valid_in,
  output logic [31:0]     bmu_a_in,
  output logic [31:0]     bmu_b_in,
  output logic [AP_W-1:0] bmu_ap,
  output logic            bmu_csr_ren_in,
  output logic [31:0]     bmu_csr_rddata_in,
  input  logic [31:0]     bmu_result_ff,
  input  logic            bmu_error,
  output logic            r0_rsp_valid,
  output logic            r1_rsp_valid,
  output logic [31:0]     rsp_result,
  output logic            rsp_error,
  output logic            busy
`ifdef BMU_ARB_PERF_EN
  ,
  output logic [31:0]     perf_gnt0,
  output logic [31:0]     perf_gnt1,
  output logic [15:0]     perf_err
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam logic [2:0] DRAIN_LD = 3'(BMU_LAT);

  state_e               state_q;
  logic                 last_gnt_q;   // 1 = r1 won the previous transfer
  logic [2:0]           drain_cnt_q;
  logic                 issue_own_q;
  logic [BMU_LAT-1:0]   tag_v_q;
  logic [BMU_LAT-1:0]   tag_own_q;

  logic gnt0, gnt1, can_issue, xfer0, xfer1, xfer, inflight;
  logic rsp_v, rsp_own;

  assign gnt0      = r0_req_valid & (~r1_req_valid | last_gnt_q);
  assign gnt1      = r1_req_valid & (~r0_req_valid | ~last_gnt_q);
  assign can_issue = (state_q != DRAIN) & ~flush & ~rst;

  assign r0_req_ready = gnt0 & can_issue;
  assign r1_req_ready = gnt1 & can_issue;

  assign xfer0 = r0_req_valid & r0_req_ready;
  assign xfer1 = r1_req_valid & r1_req_ready;
  assign xfer  = xfer0 | xfer1;

  // Ops that will still be in flight after this edge (last tag stage retires now).
  always_comb begin
    inflight = bmu_valid_in;
    for (int i = 0; i < BMU_LAT - 1; i++) begin
      inflight = inflight | tag_v_q[i];
    end
  end

  assign rsp_v        = tag_v_q[BMU_LAT-1];
  assign rsp_own      = tag_own_q[BMU_LAT-1];
  assign r0_rsp_valid = rsp_v & ~rsp_own;
  assign r1_rsp_valid = rsp_v & rsp_own;
  assign rsp_result   = rsp_v ? bmu_result_ff : 32'd0;
  assign rsp_error    = rsp_v & bmu_error;
  assign busy         = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      last_gnt_q        <= 1'b1;
      drain_cnt_q       <= 3'd0;
      issue_own_q       <= 1'b0;
      tag_v_q           <= '0;
      tag_own_q         <= '0;
      bmu_valid_in      <= 1'b0;
      bmu_a_in          <= 32'd0;
      bmu_b_in          <= 32'd0;
      bmu_ap            <= '0;
      bmu_csr_ren_in    <= 1'b0;
      bmu_csr_rddata_in <= 32'd0;
    end else begin
      bmu_valid_in <= xfer;
      if (xfer) begin
        last_gnt_q        <= xfer1;
        issue_own_q       <= xfer1;
        bmu_a_in          <= xfer1 ? r1_a : r0_a;
        bmu_b_in          <= xfer1 ? r1_b : r0_b;
        bmu_ap            <= xfer1 ? r1_ap : r0_ap;
        bmu_csr_ren_in    <= xfer1 & r1_csr_ren;
        bmu_csr_rddata_in <= xfer1 ? r1_csr_rddata : 32'd0;
      end

      tag_v_q[0]   <= bmu_valid_in & ~flush;
      tag_own_q[0] <= issue_own_q;
      for (int i = 1; i < BMU_LAT; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1] & ~flush;
        tag_own_q[i] <= tag_own_q[i-1];
      end

      if (flush) begin
        state_q     <= DRAIN;
        drain_cnt_q <= DRAIN_LD;
      end else begin
        case (state_q)
          IDLE: if (xfer) state_q <= RUN;
          RUN:  if (!xfer && !inflight) state_q <= IDLE;
          DRAIN: begin
            if (drain_cnt_q <= 3'd1) begin
              state_q     <= IDLE;
              drain_cnt_q <= 3'd0;
            end else begin
              drain_cnt_q <= drain_cnt_q - 3'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef BMU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_gnt0 <= 32'd0;
      perf_gnt1 <= 32'd0;
      perf_err  <= 16'd0;
    end else begin
      if (xfer0) perf_gnt0 <= perf_gnt0 + 32'd1;
      if (xfer1) perf_gnt1 <= perf_gnt1 + 32'd1;
      if (rsp_error && perf_err != 16'hFFFF) perf_err <= perf_err + 16'd1;
    end
  end
`endif

endmodule
